// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter.
//
// Purpose: bundles the two requester channels (A and B) that share the single
// register-file access port.
//
// Handshake: REQ_x together with WE_x/ADDR_x/WDATA_x forms the request. The
// arbiter raises GNT_x in the same cycle (combinationally) when it takes that
// request. The requester must hold REQ_x/WE_x/ADDR_x/WDATA_x stable until it
// sees GNT_x. A granted read returns RDATA_x with a one-cycle RVALID_x pulse
// two cycles after GNT_x. A granted write returns nothing. RDATA_x keeps its
// value between reads.
//
// Signals (per requester x in {A, B}):
//   REQ_x     requester -> arbiter   operation request
//   WE_x      requester -> arbiter   1 = write, 0 = read
//   ADDR_x    requester -> arbiter   register index
//   WDATA_x   requester -> arbiter   write data
//   GNT_x     arbiter -> requester   request accepted this cycle
//   RVALID_x  arbiter -> requester   RDATA_x valid pulse
//   RDATA_x   arbiter -> requester   read result
//
// Modports: master = requester side, slave = arbiter side.
interface regfile_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  REQ_A;
  logic                  WE_A;
  logic [ADDR_WIDTH-1:0] ADDR_A;
  logic [DATA_WIDTH-1:0] WDATA_A;
  logic                  GNT_A;
  logic                  RVALID_A;
  logic [DATA_WIDTH-1:0] RDATA_A;

  logic                  REQ_B;
  logic                  WE_B;
  logic [ADDR_WIDTH-1:0] ADDR_B;
  logic [DATA_WIDTH-1:0] WDATA_B;
  logic                  GNT_B;
  logic                  RVALID_B;
  logic [DATA_WIDTH-1:0] RDATA_B;

  modport master (
    output REQ_A, WE_A, ADDR_A, WDATA_A,
    input  GNT_A, RVALID_A, RDATA_A,
    output REQ_B, WE_B, ADDR_B, WDATA_B,
    input  GNT_B, RVALID_B, RDATA_B
  );

  modport slave (
    input  REQ_A, WE_A, ADDR_A, WDATA_A,
    output GNT_A, RVALID_A, RDATA_A,
    input  REQ_B, WE_B, ADDR_B, WDATA_B,
    output GNT_B, RVALID_B, RDATA_B
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter.
//
// Purpose: shares the single access port of a 2**ADDR_WIDTH x DATA_WIDTH
// register file (read-select decoder plus one write port) between two
// requesters A and B. Round-robin arbitration, one operation per cycle,
// two-stage pipeline: grant -> drive register file (S1) -> return read data.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   bus        requester channels A and B (slave modport)
//   RF_SELECT  read select to the register-file decoder (holds when idle)
//   RF_RDATA   decoder output for RF_SELECT
//   RF_WE      register-file write enable
//   RF_WADDR   register-file write index
//   RF_WDATA   register-file write data
module regfile_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_port_arbiter_if.slave bus,
  output logic [ADDR_WIDTH-1:0] RF_SELECT,
  input  logic [DATA_WIDTH-1:0] RF_RDATA,
  output logic                  RF_WE,
  output logic [ADDR_WIDTH-1:0] RF_WADDR,
  output logic [DATA_WIDTH-1:0] RF_WDATA
);

  // Round-robin pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic pri_q, pri_d;

  // Stage 1: the operation currently driving the register file.
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_owner_q, s1_owner_d;   // 0 = A, 1 = B
  logic                  s1_we_q,    s1_we_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_wdata_q, s1_wdata_d;

  // Stage 2: read results returned to the requesters.
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q,  rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q,  rdata_b_d;

  logic gnt_a;
  logic gnt_b;
  logic rd_done;

  // Grant decision. Reset suppresses all grants so nothing enters the pipe.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      if (bus.REQ_A && bus.REQ_B) begin
        if (pri_q) gnt_b = 1'b1;
        else       gnt_a = 1'b1;
      end else if (bus.REQ_A) begin
        gnt_a = 1'b1;
      end else if (bus.REQ_B) begin
        gnt_b = 1'b1;
      end
    end
  end

  // Pointer update and stage-1 load. Address/data/type hold when idle so the
  // read select keeps its last value.
  always_comb begin
    pri_d      = pri_q;
    s1_valid_d = gnt_a | gnt_b;
    s1_owner_d = s1_owner_q;
    s1_we_d    = s1_we_q;
    s1_addr_d  = s1_addr_q;
    s1_wdata_d = s1_wdata_q;
    if (gnt_a) begin
      pri_d      = 1'b1;
      s1_owner_d = 1'b0;
      s1_we_d    = bus.WE_A;
      s1_addr_d  = bus.ADDR_A;
      s1_wdata_d = bus.WDATA_A;
    end else if (gnt_b) begin
      pri_d      = 1'b0;
      s1_owner_d = 1'b1;
      s1_we_d    = bus.WE_B;
      s1_addr_d  = bus.ADDR_B;
      s1_wdata_d = bus.WDATA_B;
    end
  end

  // Stage 2: capture decoder output for a read sitting in S1.
  assign rd_done = s1_valid_q & ~s1_we_q;

  always_comb begin
    rvalid_a_d = rd_done & ~s1_owner_q;
    rvalid_b_d = rd_done &  s1_owner_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    if (rvalid_a_d) rdata_a_d = RF_RDATA;
    if (rvalid_b_d) rdata_b_d = RF_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pri_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_owner_q <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      pri_q      <= pri_d;
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      s1_we_q    <= s1_we_d;
      s1_addr_q  <= s1_addr_d;
      s1_wdata_q <= s1_wdata_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  // The register file commits on the same edge that resets us, so a write in
  // S1 is masked while RST is high; otherwise it would land despite the reset.
  assign RF_SELECT = s1_addr_q;
  assign RF_WADDR  = s1_addr_q;
  assign RF_WDATA  = s1_wdata_q;
  assign RF_WE     = s1_valid_q & s1_we_q & ~RST;

  assign bus.GNT_A    = gnt_a;
  assign bus.GNT_B    = gnt_b;
  assign bus.RVALID_A = rvalid_a_q;
  assign bus.RVALID_B = rvalid_b_q;
  assign bus.RDATA_A  = rdata_a_q;
  assign bus.RDATA_B  = rdata_b_q;

endmodule
